// File: rtl/branch_predictor.sv
// Two-slot fetch branch predictor: a 32-entry direct-mapped table of target and 2-bit counter.
// Latency: one cycle from an accepted request to registered pre_valid/npc/pre; a table update becomes visible at the next edge.
// Backpressure: stall holds the registered outputs and refuses new requests; flush kills the in-flight lookup; updates are never blocked.
module branch_predictor (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        pre_valid,
    output logic [31:0] npc,
    output logic [63:0] pre
);

    localparam int ENTRIES = 32;
    localparam int TAG_W   = 25;
    localparam int TGT_W   = 30;

    // Table storage: the valid bits are reset, the payload fields are not.
    logic [ENTRIES-1:0] ent_valid;
    logic [TAG_W-1:0]   ent_tag [ENTRIES];
    logic [TGT_W-1:0]   ent_tgt [ENTRIES];
    logic [1:0]         ent_ctr [ENTRIES];

    // Both slots of a packet share the same tag and differ only in index bit 0.
    logic [4:0]       idx0;
    logic [4:0]       idx1;
    logic [TAG_W-1:0] req_tag;
    logic             hit0;
    logic             hit1;
    logic             tkn0;
    logic             tkn1;

    assign idx0    = {req_pc[6:3], 1'b0};
    assign idx1    = {req_pc[6:3], 1'b1};
    assign req_tag = req_pc[31:7];

    // Slot 0 is behind the fetch point when req_pc[2] is set, so it is not considered.
    assign hit0 = ~req_pc[2] & ent_valid[idx0] & (ent_tag[idx0] == req_tag);
    assign hit1 = ent_valid[idx1] & (ent_tag[idx1] == req_tag);
    assign tkn0 = hit0 & ent_ctr[idx0][1];
    assign tkn1 = hit1 & ent_ctr[idx1][1];

    logic        lk_taken;
    logic        lk_slot;
    logic [1:0]  lk_ctr;
    logic [31:0] lk_npc;
    logic [63:0] lk_pre;

    // Pick the first predicted-taken slot in address order, else fall through to the next packet.
    always_comb begin
        lk_taken = 1'b0;
        lk_slot  = 1'b0;
        lk_ctr   = 2'b00;
        lk_npc   = {req_pc[31:3] + 29'd1, 3'b000};
        if (tkn0) begin
            lk_taken = 1'b1;
            lk_slot  = 1'b0;
            lk_ctr   = ent_ctr[idx0];
            lk_npc   = {ent_tgt[idx0], 2'b00};
        end else if (tkn1) begin
            lk_taken = 1'b1;
            lk_slot  = 1'b1;
            lk_ctr   = ent_ctr[idx1];
            lk_npc   = {ent_tgt[idx1], 2'b00};
        end
    end

    assign lk_pre = {26'd0, lk_ctr, lk_taken, hit0 | hit1, lk_slot, lk_taken, lk_npc};

    // Update-side decode: hit detection and the saturating counter step.
    logic [4:0]       u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr_nxt;

    assign u_idx = upd_pc[6:2];
    assign u_tag = upd_pc[31:7];
    assign u_hit = ent_valid[u_idx] & (ent_tag[u_idx] == u_tag);

    // Saturating up/down step of the hit entry's counter.
    always_comb begin
        u_ctr_nxt = ent_ctr[u_idx];
        if (upd_taken) begin
            if (ent_ctr[u_idx] != 2'd3) u_ctr_nxt = ent_ctr[u_idx] + 2'd1;
        end else begin
            if (ent_ctr[u_idx] != 2'd0) u_ctr_nxt = ent_ctr[u_idx] - 2'd1;
        end
    end

    // Word alignment makes the low two address bits meaningless here.
    logic unused_low_bits;
    assign unused_low_bits = ^{req_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Valid bits: cleared by reset, set when a taken miss allocates an entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ent_valid <= '0;
        end else if (upd_valid && upd_taken && !u_hit) begin
            ent_valid[u_idx] <= 1'b1;
        end
    end

    // Entry payload: train on hit, allocate on taken miss, ignore not-taken miss.
    always_ff @(posedge clk) begin
        if (rstn && upd_valid) begin
            if (u_hit) begin
                ent_ctr[u_idx] <= u_ctr_nxt;
                if (upd_taken) ent_tgt[u_idx] <= upd_target[31:2];
            end else if (upd_taken) begin
                ent_tag[u_idx] <= u_tag;
                ent_tgt[u_idx] <= upd_target[31:2];
                ent_ctr[u_idx] <= 2'd2;
            end
        end
    end

    // Registered prediction: flush beats stall, stall beats a new request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_valid <= 1'b0;
            npc       <= 32'd0;
            pre       <= 64'd0;
        end else if (flush) begin
            pre_valid <= 1'b0;
        end else if (stall) begin
            pre_valid <= pre_valid;
        end else if (req_valid) begin
            pre_valid <= 1'b1;
            npc       <= lk_npc;
            pre       <= lk_pre;
        end else begin
            pre_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random traffic.
// Expected outputs come from an address-level reference model of the predictor table.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same offset.
module tb_branch_predictor;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        stall;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        pre_valid;
    logic [31:0] npc;
    logic [63:0] pre;

    branch_predictor dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .stall      (stall),
        .flush      (flush),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .pre_valid  (pre_valid),
        .npc        (npc),
        .pre        (pre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one record per table slot, keyed by the word address of the branch.
    bit          m_valid [32];
    logic [24:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    int          m_ctr   [32];

    logic        exp_vld;
    logic [31:0] exp_npc;
    logic [63:0] exp_pre;
    bit          exp_known;

    function automatic logic [63:0] model_predict(input logic [31:0] pc);
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] nxt;
        logic [4:0]  i;
        logic [1:0]  c;
        bit          hit_any;
        bit          taken;
        bit          sel;
        base    = pc & 32'hFFFF_FFF8;
        nxt     = base + 32'd8;
        hit_any = 0;
        taken   = 0;
        sel     = 0;
        c       = 2'd0;
        for (int s = (pc[2] ? 1 : 0); s < 2; s++) begin
            a = base + 32'(4 * s);
            i = a[6:2];
            if (m_valid[i] && m_tag[i] == a[31:7]) begin
                hit_any = 1;
                if (!taken && m_ctr[i] >= 2) begin
                    taken = 1;
                    sel   = (s == 1);
                    nxt   = m_tgt[i];
                    c     = 2'(m_ctr[i]);
                end
            end
        end
        return {26'd0, c, taken, hit_any, sel, taken, nxt};
    endfunction

    task automatic model_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        logic [4:0] i;
        i = pc[6:2];
        if (m_valid[i] && m_tag[i] == pc[31:7]) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt & 32'hFFFF_FFFC;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[i] = 1;
            m_tag[i]   = pc[31:7];
            m_tgt[i]   = tgt & 32'hFFFF_FFFC;
            m_ctr[i]   = 2;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare.
    task automatic cyc(input bit r_n, input bit rv, input logic [31:0] rpc,
                       input bit st, input bit fl,
                       input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
        logic [63:0] p;
        rstn       = r_n;
        req_valid  = rv;
        req_pc     = rpc;
        stall      = st;
        flush      = fl;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        @(posedge clk);
        if (!r_n) begin
            for (int k = 0; k < 32; k++) m_valid[k] = 0;
            exp_vld   = 0;
            exp_npc   = 32'd0;
            exp_pre   = 64'd0;
            exp_known = 1;
        end else begin
            p = model_predict(rpc);
            if (fl) begin
                exp_vld   = 0;
                exp_known = 0;
            end else if (st) begin
                exp_vld = exp_vld;
            end else if (rv) begin
                exp_vld   = 1;
                exp_pre   = p;
                exp_npc   = p[31:0];
                exp_known = 1;
            end else begin
                exp_vld   = 0;
                exp_known = 0;
            end
            if (uv) model_update(upc, ut, utg);
        end
        #1;
        chk("pre_valid", 64'(pre_valid), 64'(exp_vld));
        if (exp_known) begin
            chk("npc", 64'(npc), 64'(exp_npc));
            chk("pre", pre, exp_pre);
        end
    endtask

    task automatic do_req(input logic [31:0] pc);
        cyc(1, 1, pc, 0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic do_upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        cyc(1, 0, 32'd0, 0, 0, 1, pc, t, tgt);
    endtask

    task automatic do_reset();
        cyc(0, 1, 32'h1000, 0, 0, 1, 32'h1004, 1, 32'h4000);
    endtask

    logic [31:0] held_npc;
    logic [63:0] held_pre;

    initial begin
        exp_vld   = 0;
        exp_npc   = 0;
        exp_pre   = 0;
        exp_known = 0;
        do_reset();
        do_reset();
        chk("reset_pre", pre, 64'd0);

        // Empty table: fall-through to the next packet.
        do_req(32'h1000);
        chk("ft_valid", 64'(pre_valid), 64'd1);
        chk("ft_npc", 64'(npc), 64'h1008);
        chk("ft_pre", pre, 64'h1008);

        // Allocate slot 1 as taken.
        do_upd(32'h1004, 1, 32'h2000);
        do_req(32'h1000);
        chk("alloc_npc", 64'(npc), 64'h2000);
        chk("alloc_bits", 64'(pre[37:32]), 64'h2F);

        // Train down to zero and check saturation at the bottom.
        do_upd(32'h1004, 0, 32'h0);
        do_upd(32'h1004, 0, 32'h0);
        do_req(32'h1000);
        chk("nt_npc", 64'(npc), 64'h1008);
        chk("nt_hit", 64'(pre[35:34]), 64'h1);
        do_upd(32'h1004, 0, 32'h0);
        do_upd(32'h1004, 1, 32'h2000);
        do_req(32'h1000);
        chk("sat0_npc", 64'(npc), 64'h1008);
        do_upd(32'h1004, 1, 32'h2000);

        // Slot priority: slot 0 wins when both are taken.
        do_upd(32'h1000, 1, 32'h3000);
        do_req(32'h1000);
        chk("prio_npc", 64'(npc), 64'h3000);
        chk("prio_slot", 64'(pre[33]), 64'd0);
        do_req(32'h1004);
        chk("slot1_npc", 64'(npc), 64'h2000);

        // Aliasing: same index, different tag misses.
        do_req(32'h1084);
        chk("alias_npc", 64'(npc), 64'h1088);
        chk("alias_hit", 64'(pre[34]), 64'd0);

        // Stall holds outputs across changing requests; flush overrides stall.
        do_req(32'h1000);
        held_npc = npc;
        held_pre = pre;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 32'h1080 + 32'(8 * k), 1, 0, 0, 32'd0, 0, 32'd0);
            chk("stall_npc", 64'(npc), 64'(held_npc));
            chk("stall_pre", pre, held_pre);
        end
        cyc(1, 1, 32'h1000, 1, 1, 0, 32'd0, 0, 32'd0);
        chk("flush_vld", 64'(pre_valid), 64'd0);

        // Same-cycle update is not bypassed into the lookup.
        cyc(1, 1, 32'h1000, 0, 0, 1, 32'h1000, 0, 32'd0);
        chk("nobyp_npc", 64'(npc), 64'h3000);
        do_req(32'h1000);
        chk("post_upd_npc", 64'(npc), 64'h2000);

        // Reset during a stall discards the held output.
        do_req(32'h1000);
        cyc(0, 1, 32'h1000, 1, 0, 0, 32'd0, 0, 32'd0);
        cyc(1, 1, 32'h1000, 1, 0, 0, 32'd0, 0, 32'd0);
        chk("rst_stall_vld", 64'(pre_valid), 64'd0);
        do_req(32'h1004);
        chk("rst_clr_npc", 64'(npc), 64'h1008);

        // Random traffic over a few tags so entries collide and alias.
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 3) != 0),
                32'h1000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 31) << 2),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 0),
                32'h1000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 31) << 2),
                ($urandom_range(0, 2) != 0),
                $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rstn  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-003 req_valid  input  1  fetch-side lookup request for packet at req_pc.
REQ-004 req_pc  input  32  fetch PC; word-aligned; req_pc[2] selects first live slot of the 8-byte packet.
REQ-005 stall  input  1  fetch stalled; holds registered outputs and ignores req_valid.
REQ-006 flush  input  1  execute-side redirect; kills the in-flight lookup.
REQ-007 upd_valid  input  1  resolved control-flow update from execute.
REQ-008 upd_pc  input  32  PC of resolved branch/jump.
REQ-009 upd_taken  input  1  resolved direction.
REQ-010 upd_target  input  32  resolved target address.
REQ-011 pre_valid  output  1  pre and npc are valid for the previous accepted request.
REQ-012 npc  output  32  predicted next fetch PC.
REQ-013 pre  output  64  prediction word carried down the pipe with the packet to execute.

Function
REQ-014 Table: 32 entries, direct-mapped, index pc[6:2], tag pc[31:7]; each entry holds valid, 25-bit tag, 30-bit target (target[31:2]), 2-bit saturating counter.
REQ-015 Lookup: slot0 address {req_pc[31:3],3'b000} (considered only when req_pc[2]==0); slot1 address {req_pc[31:3],3'b100}.
REQ-016 Slot predicted-taken when entry valid, tag matches, counter>=2.
REQ-017 Selection: first considered predicted-taken slot in address order; none -> fall-through.
REQ-018 Latency: a request accepted at edge N (req_valid=1, stall=0, flush=0) produces pre_valid=1 with pre/npc after edge N; registered outputs, one-cycle latency.
REQ-019 npc = selected target, or {req_pc[31:3]+29'b1,3'b000} on fall-through.
REQ-020 pre[31:0] = npc; pre[32] = predicted taken; pre[33] = selected slot (0/1, 0 on fall-through); pre[34] = tag hit on any considered slot; pre[35] = predicted taken (npc redirected from fall-through); pre[37:36] = counter of selected slot (00 on fall-through); pre[63:38] = 0.
REQ-021 stall=1: pre_valid, pre, npc hold; no lookup accepted.
REQ-022 flush=1: pre_valid=0 after the edge, overriding stall and req_valid; pre/npc contents don't-care.
REQ-023 req_valid=0, stall=0, flush=0: pre_valid=0 after the edge.
REQ-024 Update, upd_valid=1, tag hit: counter +1 if taken (saturate 3), -1 if not taken (saturate 0); target written only when taken.
REQ-025 Update, tag miss or invalid, taken: allocate/overwrite entry with valid=1, new tag, target, counter=2.
REQ-026 Update, tag miss, not taken: no change.
REQ-027 Update visible to lookups from the next edge; same-cycle lookup reads pre-update state (no bypass).
REQ-028 Updates are applied regardless of stall and flush.

Reset
REQ-029 rstn=0 at an edge: all entry valid bits cleared, pre_valid=0, pre=64'b0, npc=32'b0; request and update that cycle discarded.
REQ-030 Reset mid-lookup or mid-stall discards held output; first valid output requires a request accepted after rstn returns to 1.

Verification
REQ-031 After reset, req_pc=0x1000 -> next cycle pre_valid=1, npc=0x1008, pre=0x0000_0000_0000_1008.
REQ-032 Update pc=0x1004 taken target=0x2000, then req_pc=0x1000 -> npc=0x2000, pre[32]=1, pre[33]=1, pre[34]=1, pre[35]=1, pre[37:36]=2.
REQ-033 Same entry: two not-taken updates -> counter 0, req_pc=0x1000 gives npc=0x1008, pre[34]=1, pre[35]=0; third not-taken update keeps counter 0.
REQ-034 Slot priority: entries at 0x1000 (->0x3000) and 0x1004 (->0x2000) taken; req_pc=0x1000 -> npc=0x3000, pre[33]=0; req_pc=0x1004 -> npc=0x2000.
REQ-035 Aliasing: entry from 0x1004 taken; req_pc=0x1084 (same index, other tag) -> fall-through 0x1088, pre[34]=0.
REQ-036 stall held 3 cycles with changing req_pc -> outputs unchanged; flush asserted with stall -> pre_valid=0 next cycle; update in same cycle as lookup of same pc -> old prediction returned, new one on next request.
